// File: rtl/vxe_cu_exec_ctrl.sv
// vxe_cu_exec_ctrl: compute-unit execution sequencer (IDLE/EXEC/SYNC/WAIT/DRAIN).
// Ports: clk/nrst; i_start, decoded i_cmd_* and sync mask; i_tmo_limit;
//   unit busy flags (fetch, dispatch/forward pipes, VPUs); fault sources.
//   o_glb_busy/o_stop_drain are combinational; o_unhalt/o_send_intr/o_complete
//   are registered one-cycle pulses; o_flt_vec/o_tmo are sticky status.
module vxe_cu_exec_ctrl #(
    parameter int VPUS_NR = 2,
    parameter int TMO_W   = 16
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               i_start,
    input  logic               i_cmd_nop,
    input  logic               i_cmd_sync,
    input  logic               i_cmd_sync_stop,
    input  logic               i_cmd_sync_intr,
    input  logic [VPUS_NR-1:0] i_cmd_sync_mask,
    input  logic [TMO_W-1:0]   i_tmo_limit,
    input  logic               i_fetch_busy,
    input  logic               i_dis_pipes_active,
    input  logic               i_fwd_pipes_active,
    input  logic [VPUS_NR-1:0] i_vpus_busy,
    input  logic               i_flt_fetch,
    input  logic               i_flt_decode,
    input  logic [VPUS_NR-1:0] i_vpus_err,
    output logic               o_glb_busy,
    output logic               o_stop_drain,
    output logic               o_unhalt,
    output logic               o_send_intr,
    output logic               o_complete,
    output logic [VPUS_NR+1:0] o_flt_vec,
    output logic               o_tmo
);

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        SYNC,
        WAIT,
        DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [TMO_W-1:0]   cnt_q, cnt_d;
    logic               intr_q, intr_d;
    logic [VPUS_NR-1:0] mask_q, mask_d;
    logic               unhalt_q, unhalt_d;
    logic               send_q, send_d;
    logic               cmpl_q, cmpl_d;
    logic [VPUS_NR+1:0] flt_q, flt_d;
    logic               tmo_q, tmo_d;

    logic               units_busy;
    logic               fault_cond;
    logic               stop_cond;
    logic               sync_wait;
    logic               tmo_hit;
    logic [VPUS_NR+1:0] flt_now;

    assign units_busy = i_fetch_busy | i_dis_pipes_active
                      | i_fwd_pipes_active | (|i_vpus_busy);
    assign fault_cond = i_flt_fetch | i_flt_decode | (|i_vpus_err);
    assign stop_cond  = i_cmd_sync & i_cmd_sync_stop;
    assign sync_wait  = i_fwd_pipes_active | (|(i_vpus_busy & mask_q));
    assign flt_now    = {i_vpus_err, i_flt_decode, i_flt_fetch};

    // Fires on the limit-th waiting cycle: the counter starts at 0.
    assign tmo_hit = (i_tmo_limit != '0)
                   && (cnt_q == i_tmo_limit - TMO_W'(1));

    assign o_glb_busy   = units_busy | (state_q != IDLE);
    assign o_stop_drain = fault_cond | stop_cond | (state_q == DRAIN);
    assign o_unhalt     = unhalt_q;
    assign o_send_intr  = send_q;
    assign o_complete   = cmpl_q;
    assign o_flt_vec    = flt_q;
    assign o_tmo        = tmo_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        intr_d   = intr_q;
        mask_d   = mask_q;
        unhalt_d = 1'b0;
        send_d   = 1'b0;
        cmpl_d   = 1'b0;
        flt_d    = flt_q;
        tmo_d    = tmo_q;

        if (state_q != IDLE)
            flt_d = flt_q | flt_now;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    flt_d   = '0;
                    tmo_d   = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (fault_cond) begin
                    state_d = DRAIN;
                end else if (!units_busy) begin
                    send_d   = 1'b1;
                    unhalt_d = 1'b1;
                    state_d  = IDLE;
                end else if (stop_cond) begin
                    intr_d  = i_cmd_sync_intr;
                    cnt_d   = '0;
                    state_d = WAIT;
                end else if (i_cmd_sync) begin
                    intr_d  = i_cmd_sync_intr;
                    mask_d  = i_cmd_sync_mask;
                    cnt_d   = '0;
                    state_d = SYNC;
                end else if (i_cmd_nop) begin
                    unhalt_d = 1'b1;
                end
            end
            SYNC: begin
                if (fault_cond) begin
                    state_d = DRAIN;
                end else if (!sync_wait) begin
                    send_d   = intr_q;
                    unhalt_d = 1'b1;
                    state_d  = EXEC;
                end else if (tmo_hit) begin
                    tmo_d   = 1'b1;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
            end
            WAIT: begin
                if (fault_cond) begin
                    state_d = DRAIN;
                end else if (!units_busy) begin
                    send_d   = intr_q;
                    cmpl_d   = intr_q;
                    unhalt_d = 1'b1;
                    state_d  = IDLE;
                end else if (tmo_hit) begin
                    tmo_d   = 1'b1;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
            end
            DRAIN: begin
                if (!units_busy) begin
                    send_d   = 1'b1;
                    unhalt_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            intr_q   <= 1'b0;
            mask_q   <= '0;
            unhalt_q <= 1'b0;
            send_q   <= 1'b0;
            cmpl_q   <= 1'b0;
            flt_q    <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            intr_q   <= intr_d;
            mask_q   <= mask_d;
            unhalt_q <= unhalt_d;
            send_q   <= send_d;
            cmpl_q   <= cmpl_d;
            flt_q    <= flt_d;
            tmo_q    <= tmo_d;
        end
    end

endmodule

// File: tb/tb_vxe_cu_exec_ctrl.sv
// tb_vxe_cu_exec_ctrl: directed self-checking bench for vxe_cu_exec_ctrl.
// Inputs change 1ns after the rising edge; outputs are sampled after that.
module tb_vxe_cu_exec_ctrl;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        i_start = 1'b0;
    logic        i_cmd_nop = 1'b0;
    logic        i_cmd_sync = 1'b0;
    logic        i_cmd_sync_stop = 1'b0;
    logic        i_cmd_sync_intr = 1'b0;
    logic [1:0]  i_cmd_sync_mask = '0;
    logic [15:0] i_tmo_limit = '0;
    logic        i_fetch_busy = 1'b0;
    logic        i_dis_pipes_active = 1'b0;
    logic        i_fwd_pipes_active = 1'b0;
    logic [1:0]  i_vpus_busy = '0;
    logic        i_flt_fetch = 1'b0;
    logic        i_flt_decode = 1'b0;
    logic [1:0]  i_vpus_err = '0;
    logic        o_glb_busy;
    logic        o_stop_drain;
    logic        o_unhalt;
    logic        o_send_intr;
    logic        o_complete;
    logic [3:0]  o_flt_vec;
    logic        o_tmo;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vxe_cu_exec_ctrl #(.VPUS_NR(2), .TMO_W(16)) dut (
        .clk                (clk),
        .nrst               (nrst),
        .i_start            (i_start),
        .i_cmd_nop          (i_cmd_nop),
        .i_cmd_sync         (i_cmd_sync),
        .i_cmd_sync_stop    (i_cmd_sync_stop),
        .i_cmd_sync_intr    (i_cmd_sync_intr),
        .i_cmd_sync_mask    (i_cmd_sync_mask),
        .i_tmo_limit        (i_tmo_limit),
        .i_fetch_busy       (i_fetch_busy),
        .i_dis_pipes_active (i_dis_pipes_active),
        .i_fwd_pipes_active (i_fwd_pipes_active),
        .i_vpus_busy        (i_vpus_busy),
        .i_flt_fetch        (i_flt_fetch),
        .i_flt_decode       (i_flt_decode),
        .i_vpus_err         (i_vpus_err),
        .o_glb_busy         (o_glb_busy),
        .o_stop_drain       (o_stop_drain),
        .o_unhalt           (o_unhalt),
        .o_send_intr        (o_send_intr),
        .o_complete         (o_complete),
        .o_flt_vec          (o_flt_vec),
        .o_tmo              (o_tmo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulses(input string tag, input logic [2:0] exp);
        chk(tag, {29'd0, o_unhalt, o_send_intr, o_complete}, {29'd0, exp});
    endtask

    task automatic cmd_clear();
        i_cmd_nop       = 1'b0;
        i_cmd_sync      = 1'b0;
        i_cmd_sync_stop = 1'b0;
        i_cmd_sync_intr = 1'b0;
        i_cmd_sync_mask = '0;
    endtask

    initial begin
        // Reset state and combinational pass-through while in reset
        #2;
        chk("rst_glb_busy", o_glb_busy, 0);
        chk("rst_stop_drain", o_stop_drain, 0);
        pulses("rst_pulses", 3'b000);
        chk("rst_flt", o_flt_vec, 0);
        chk("rst_tmo", o_tmo, 0);
        i_fetch_busy = 1'b1;
        i_cmd_sync = 1'b1;
        i_cmd_sync_stop = 1'b1;
        #1;
        chk("rst_glb_follow", o_glb_busy, 1);
        chk("rst_stop_follow", o_stop_drain, 1);
        i_fetch_busy = 1'b0;
        cmd_clear();
        #4;
        nrst = 1'b1;
        tick();
        chk("idle_glb_busy", o_glb_busy, 0);

        // SYNC exit in one cycle: masked VPU0 idle, VPU1 busy
        i_start = 1'b1;
        i_fetch_busy = 1'b1;
        tick();
        i_start = 1'b0;
        #1;
        chk("exec_glb_busy", o_glb_busy, 1);
        i_cmd_sync = 1'b1;
        i_cmd_sync_intr = 1'b1;
        i_cmd_sync_mask = 2'b01;
        i_vpus_busy = 2'b10;
        tick();
        cmd_clear();
        tick();
        pulses("sync_exit", 3'b110);
        tick();
        pulses("exec_quiet", 3'b000);
        i_fetch_busy = 1'b0;
        i_vpus_busy = 2'b00;
        tick();
        pulses("exec_done", 3'b110);
        chk("exec_done_idle", o_glb_busy, 0);
        tick();
        pulses("idle_quiet", 3'b000);

        // NOP in EXEC pulses unhalt only
        i_start = 1'b1;
        i_dis_pipes_active = 1'b1;
        tick();
        i_start = 1'b0;
        i_cmd_nop = 1'b1;
        tick();
        i_cmd_nop = 1'b0;
        pulses("nop_unhalt", 3'b100);
        i_dis_pipes_active = 1'b0;
        tick();
        tick();

        // SYNC+STOP: WAIT holds 5 busy cycles, then completes
        i_start = 1'b1;
        i_fetch_busy = 1'b1;
        tick();
        i_start = 1'b0;
        i_cmd_sync = 1'b1;
        i_cmd_sync_stop = 1'b1;
        i_cmd_sync_intr = 1'b1;
        #1;
        chk("stop_cond_comb", o_stop_drain, 1);
        tick();
        cmd_clear();
        for (int i = 0; i < 5; i++) begin
            tick();
            pulses("wait_hold", 3'b000);
        end
        chk("wait_busy", o_glb_busy, 1);
        i_fetch_busy = 1'b0;
        tick();
        pulses("wait_exit", 3'b111);
        chk("wait_exit_idle", o_glb_busy, 0);

        // Timeout with limit 4 in SYNC
        i_tmo_limit = 16'd4;
        i_start = 1'b1;
        i_fetch_busy = 1'b1;
        tick();
        i_start = 1'b0;
        i_cmd_sync = 1'b1;
        i_cmd_sync_mask = 2'b01;
        i_vpus_busy = 2'b01;
        tick();
        cmd_clear();
        tick();
        tick();
        tick();
        chk("tmo_not_yet", o_tmo, 0);
        chk("tmo_not_drain", o_stop_drain, 0);
        tick();
        chk("tmo_fired", o_tmo, 1);
        chk("tmo_drain", o_stop_drain, 1);
        tick();
        pulses("drain_hold", 3'b000);
        i_fetch_busy = 1'b0;
        i_vpus_busy = 2'b00;
        tick();
        pulses("drain_exit", 3'b110);
        chk("tmo_sticky", o_tmo, 1);
        i_tmo_limit = 16'd0;

        // VPU1 fault in EXEC
        i_start = 1'b1;
        i_fetch_busy = 1'b1;
        tick();
        i_start = 1'b0;
        chk("start_clr_tmo", o_tmo, 0);
        i_vpus_err = 2'b10;
        #1;
        chk("flt_stop_comb", o_stop_drain, 1);
        tick();
        i_vpus_err = 2'b00;
        #1;
        chk("flt_vec", o_flt_vec, 4'b1000);
        chk("flt_drain", o_stop_drain, 1);
        i_fetch_busy = 1'b0;
        tick();
        pulses("flt_drain_exit", 3'b110);
        chk("flt_sticky", o_flt_vec, 4'b1000);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("flt_cleared", o_flt_vec, 0);
        tick();
        tick();

        // No timeout when limit is 0, 1000 busy SYNC cycles
        i_start = 1'b1;
        i_fetch_busy = 1'b1;
        tick();
        i_start = 1'b0;
        i_cmd_sync = 1'b1;
        i_cmd_sync_intr = 1'b1;
        i_cmd_sync_mask = 2'b11;
        i_vpus_busy = 2'b01;
        tick();
        cmd_clear();
        repeat (1000) tick();
        chk("notmo_flag", o_tmo, 0);
        chk("notmo_busy", o_glb_busy, 1);
        chk("notmo_stop", o_stop_drain, 0);
        i_vpus_busy = 2'b00;
        tick();
        pulses("notmo_exit", 3'b110);
        i_fetch_busy = 1'b0;
        tick();
        tick();

        // Reset asserted while in WAIT
        i_start = 1'b1;
        i_fetch_busy = 1'b1;
        tick();
        i_start = 1'b0;
        i_cmd_sync = 1'b1;
        i_cmd_sync_stop = 1'b1;
        i_cmd_sync_intr = 1'b1;
        i_flt_decode = 1'b0;
        tick();
        cmd_clear();
        tick();
        i_fetch_busy = 1'b0;
        nrst = 1'b0;
        #1;
        chk("mid_rst_idle", o_glb_busy, 0);
        pulses("mid_rst_pulses", 3'b000);
        chk("mid_rst_tmo", o_tmo, 0);
        tick();
        #2;
        nrst = 1'b1;
        tick();
        pulses("post_rst_1", 3'b000);
        tick();
        pulses("post_rst_2", 3'b000);
        chk("post_rst_idle", o_glb_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vxe_cu_exec_ctrl.md
VXE_CU_EXEC_CTRL -- requirements
Module: vxe_cu_exec_ctrl

Interface
REQ-001 SHALL provide parameter VPUS_NR, default 2, number of VPUs.
REQ-002 SHALL provide parameter TMO_W, default 16, width of the sync/wait timeout counter.
REQ-003 SHALL provide clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL provide nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide i_start  input  1  start execution; honoured only in IDLE.
REQ-006 SHALL provide i_cmd_nop, i_cmd_sync, i_cmd_sync_stop, i_cmd_sync_intr  input  1 each  decoded command state.
REQ-007 SHALL provide i_cmd_sync_mask  input  VPUS_NR  VPUs a SYNC waits on.
REQ-008 SHALL provide i_tmo_limit  input  TMO_W  timeout limit in cycles; 0 disables the timeout.
REQ-009 SHALL provide i_fetch_busy, i_dis_pipes_active, i_fwd_pipes_active  input  1 each; i_vpus_busy  input  VPUS_NR.
REQ-010 SHALL provide i_flt_fetch, i_flt_decode  input  1 each; i_vpus_err  input  VPUS_NR  fault sources.
REQ-011 SHALL provide o_glb_busy, o_stop_drain  output  1 each  combinational.
REQ-012 SHALL provide o_unhalt, o_send_intr, o_complete  output  1 each  registered single-cycle pulses.
REQ-013 SHALL provide o_flt_vec  output  VPUS_NR+2  sticky faults: bit0 fetch, bit1 decode, bit[2+i] VPU i.
REQ-014 SHALL provide o_tmo  output  1  sticky timeout flag.

Function
REQ-015 SHALL define units_busy = i_fetch_busy | i_dis_pipes_active | i_fwd_pipes_active | OR(i_vpus_busy).
REQ-016 SHALL define fault_cond = i_flt_fetch | i_flt_decode | OR(i_vpus_err); stop_cond = i_cmd_sync & i_cmd_sync_stop.
REQ-017 SHALL implement states IDLE, EXEC, SYNC, WAIT, DRAIN.
REQ-018 SHALL drive o_glb_busy = units_busy | (state != IDLE).
REQ-019 SHALL drive o_stop_drain = fault_cond | stop_cond | (state == DRAIN).
REQ-020 SHALL default o_unhalt, o_send_intr and o_complete to 0 every cycle unless set below.
REQ-021 IDLE: on i_start SHALL clear o_flt_vec and o_tmo and go to EXEC next cycle.
REQ-022 EXEC, first match wins: fault_cond -> DRAIN; !units_busy -> pulse o_send_intr=1, o_complete=0, o_unhalt=1, go IDLE; stop_cond -> latch i_cmd_sync_intr, go WAIT; i_cmd_sync -> latch i_cmd_sync_intr and i_cmd_sync_mask, go SYNC; i_cmd_nop -> pulse o_unhalt.
REQ-023 SYNC: sync_wait = i_fwd_pipes_active | OR(i_vpus_busy & latched mask); a fault goes to DRAIN; else !sync_wait pulses o_send_intr=latched intr and o_unhalt=1, then goes to EXEC.
REQ-024 WAIT: a fault goes to DRAIN; else !units_busy pulses o_send_intr=o_complete=latched intr and o_unhalt=1, then goes to IDLE.
REQ-025 SHALL clear the timeout counter on entry to SYNC or WAIT and increment it by 1 each cycle in those states while the exit condition is false.
REQ-026 When i_tmo_limit != 0 and the counter equals i_tmo_limit-1 while the exit condition is false, SHALL set o_tmo and go to DRAIN; the timeout fires on the i_tmo_limit-th waiting cycle.
REQ-027 Priority in SYNC/WAIT: fault > exit condition > timeout; exit on the same cycle as the timeout SHALL NOT set o_tmo.
REQ-028 DRAIN: when !units_busy SHALL pulse o_send_intr=1, o_complete=0, o_unhalt=1 and go to IDLE; otherwise stay in DRAIN.
REQ-029 In every non-IDLE state SHALL OR the current fault sources into o_flt_vec each cycle.
REQ-030 SHALL ignore i_start outside IDLE, and SHALL ignore command inputs in SYNC, WAIT, DRAIN and IDLE.

Reset
REQ-031 On nrst low SHALL go to IDLE and zero o_unhalt, o_send_intr, o_complete, o_flt_vec, o_tmo, the timeout counter, latched intr and latched mask, including mid-operation.
REQ-032 After reset the combinational outputs SHALL follow the inputs only: o_glb_busy = units_busy and o_stop_drain = fault_cond | stop_cond.

Verification
REQ-033 Scenario: start, fetch busy, SYNC intr=1, mask=2'b01, VPU1 busy and VPU0 idle -> exit SYNC in 1 cycle, o_send_intr=1, o_unhalt=1, o_complete=0.
REQ-034 Scenario: SYNC+STOP intr=1, units busy 5 cycles -> in WAIT 5 cycles, then o_send_intr=o_complete=1, IDLE, o_glb_busy=0.
REQ-035 Scenario: i_tmo_limit=4, SYNC with masked VPU stuck busy -> DRAIN after 4 waiting cycles, o_tmo=1; when units idle, o_send_intr=1, o_complete=0.
REQ-036 Scenario: i_vpus_err[1] pulsed in EXEC with units busy -> o_stop_drain=1, DRAIN, o_flt_vec=4'b1000; on the next i_start o_flt_vec=0.
REQ-037 Scenario: i_tmo_limit=0, SYNC busy 1000 cycles -> no timeout, o_tmo=0; exit normally.
REQ-038 Scenario: nrst asserted in WAIT -> IDLE immediately, all registered outputs 0, no o_send_intr pulse after release.
